playback_deserializer: RTL and testbench



---
 rtl/audio_pkg.sv | 7 +
 rtl/bit_rate_prescaler.sv | 20 ++
 rtl/playback_deserializer.sv | 93 +++++++++
 tb/tb_playback_deserializer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared audio datapath defaults and controller/deserializer state encodings
package audio_pkg;
    localparam int DEFAULT_WORD_LENGTH = 16;
    localparam int DEFAULT_CLOCK_DIV = 42;
    typedef enum logic {DESER_STATE_IDLE, DESER_STATE_SHIFT} deserializer_state_t;
    typedef enum logic [1:0] {CTRL_STATE_IDLE, CTRL_STATE_RECORD, CTRL_STATE_PLAYBACK} controller_state_t;
endpackage

// File: rtl/bit_rate_prescaler.sv
// bit_rate_prescaler: counts 0..CLOCK_DIV-1 while enabled and flags the last count as a bit tick
module bit_rate_prescaler #(
    parameter int CLOCK_DIV = 42
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);
    localparam int PW = $clog2(CLOCK_DIV);
    localparam logic [PW-1:0] LAST = PW'(CLOCK_DIV - 1);
    logic [PW-1:0] count_q, count_d;
    assign tick_o = enable_i && (count_q == LAST);
    always_comb count_d = (clear_i || tick_o) ? '0 : (enable_i ? count_q + 1'b1 : count_q);
    always_ff @(posedge clock_i) begin
        if (reset_i) count_q <= '0;
        else count_q <= count_d;
    end
endmodule

// File: rtl/playback_deserializer.sv
// playback_deserializer: shifts memory words out serially to the audio PWM line with a done handshake.
// Define PLAYBACK_LSB_FIRST_EN to emit each word LSB first instead of MSB first.
module playback_deserializer
    import audio_pkg::*;
#(
    parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH,
    parameter int CLOCK_DIV = DEFAULT_CLOCK_DIV
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic [WORD_LENGTH-1:0] data_i,
    output logic                   done_o,
    output logic                   audio_pwm_o,
    output logic                   audio_sd_o,
    output logic                   busy_o
);
    localparam int CW = $clog2(WORD_LENGTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_LENGTH - 1);
    deserializer_state_t state_q, state_d;
    logic [WORD_LENGTH-1:0] shreg_q, shreg_d, shifted;
    logic [CW-1:0] cnt_q, cnt_d;
    logic done_q, done_d, pwm_q, pwm_d, sd_q, sd_d;
    logic tick, presc_clear, out_bit;

    bit_rate_prescaler #(.CLOCK_DIV(CLOCK_DIV)) u_prescaler (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clear_i (presc_clear),
        .enable_i(state_q == DESER_STATE_SHIFT),
        .tick_o  (tick)
    );

`ifdef PLAYBACK_LSB_FIRST_EN
    assign shifted = shreg_q >> 1;
    assign out_bit = shreg_d[0];
`else
    assign shifted = shreg_q << 1;
    assign out_bit = shreg_d[WORD_LENGTH-1];
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d = cnt_q;
        done_d = 1'b0;
        presc_clear = 1'b0;
        if (state_q == DESER_STATE_IDLE) begin
            if (enable_i) begin
                state_d = DESER_STATE_SHIFT;
                shreg_d = data_i;
                cnt_d = '0;
                presc_clear = 1'b1;
            end
        end else if (tick) begin
            if (cnt_q == LAST_BIT) begin
                // final-bit decision uses enable_i on this edge: reload seamlessly or drain to idle
                done_d = 1'b1;
                cnt_d = '0;
                shreg_d = enable_i ? data_i : '0;
                state_d = enable_i ? DESER_STATE_SHIFT : DESER_STATE_IDLE;
            end else begin
                shreg_d = shifted;
                cnt_d = cnt_q + 1'b1;
            end
        end
        pwm_d = (state_d == DESER_STATE_SHIFT) && out_bit;
        sd_d = state_d == DESER_STATE_SHIFT;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= DESER_STATE_IDLE;
            shreg_q <= '0;
            cnt_q <= '0;
            done_q <= 1'b0;
            pwm_q <= 1'b0;
            sd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q <= cnt_d;
            done_q <= done_d;
            pwm_q <= pwm_d;
            sd_q <= sd_d;
        end
    end

    assign done_o = done_q;
    assign audio_pwm_o = pwm_q;
    assign audio_sd_o = sd_q;
    assign busy_o = state_q == DESER_STATE_SHIFT;
endmodule

// File: tb/tb_playback_deserializer.sv
// tb_playback_deserializer: directed checks of the deserializer with WORD_LENGTH=8, CLOCK_DIV=4
module tb_playback_deserializer;
    logic clk = 1'b0;
    logic reset_i, enable_i, done_o, audio_pwm_o, audio_sd_o, busy_o;
    logic [7:0] data_i;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    playback_deserializer #(.WORD_LENGTH(8), .CLOCK_DIV(4)) dut (
        .clock_i    (clk),
        .reset_i    (reset_i),
        .enable_i   (enable_i),
        .data_i     (data_i),
        .done_o     (done_o),
        .audio_pwm_o(audio_pwm_o),
        .audio_sd_o (audio_sd_o),
        .busy_o     (busy_o)
    );

    function automatic logic exp_bit(input logic [7:0] d, input int idx);
`ifdef PLAYBACK_LSB_FIRST_EN
        return d[idx];
`else
        return d[7-idx];
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; enable_i = 1'b1; data_i = 8'hFF;
        step(); step();
        checks++;
        if ({done_o, audio_pwm_o, audio_sd_o, busy_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0000", {done_o, audio_pwm_o, audio_sd_o, busy_o});
        end
        reset_i = 1'b0; enable_i = 1'b0;
        step();
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy got %b want 0", busy_o); end
    endtask

    task automatic test_word(input logic [7:0] d);
        int done_cnt = 0;
        data_i = d; enable_i = 1'b1;
        step();
        for (int c = 1; c <= 32; c++) begin
            checks++;
            if (audio_pwm_o !== exp_bit(d, (c - 1) / 4)) begin
                errors++; $display("FAIL word_%h_pwm cycle %0d got %b want %b", d, c, audio_pwm_o, exp_bit(d, (c - 1) / 4));
            end
            if (audio_sd_o !== 1'b1 || busy_o !== 1'b1) done_cnt += 100;
            if (done_o) done_cnt++;
            step();
        end
        checks++;
        if (done_cnt != 0) begin errors++; $display("FAIL word_%h_during got %0d want 0", d, done_cnt); end
        checks++;
        if (done_o !== 1'b1) begin errors++; $display("FAIL word_%h_done_c33 got %b want 1", d, done_o); end
        checks++;
        if (audio_pwm_o !== exp_bit(d, 0) || audio_sd_o !== 1'b1) begin
            errors++; $display("FAIL word_%h_reload got pwm %b sd %b want %b 1", d, audio_pwm_o, audio_sd_o, exp_bit(d, 0));
        end
        enable_i = 1'b0;
        for (int i = 0; i < 40 && busy_o; i++) step();
        checks++;
        if (busy_o !== 1'b0 || audio_sd_o !== 1'b0) begin
            errors++; $display("FAIL word_%h_drain got busy %b sd %b want 0 0", d, busy_o, audio_sd_o);
        end
    endtask

    task automatic test_back_to_back();
        int done_at[$];
        int bad_pwm = 0;
        data_i = 8'hFF; enable_i = 1'b1;
        step();
        for (int c = 1; c <= 66; c++) begin
            if (done_o) done_at.push_back(c);
            if (c <= 32 && audio_pwm_o !== 1'b1) bad_pwm++;
            if (c > 32 && c <= 64 && (audio_pwm_o !== 1'b0 || audio_sd_o !== 1'b1)) bad_pwm++;
            if (c == 32) data_i = 8'h00;
            if (c == 40) enable_i = 1'b0;
            if (c == 65) begin
                checks++;
                if (busy_o !== 1'b0 || audio_sd_o !== 1'b0) begin
                    errors++; $display("FAIL b2b_idle got busy %b sd %b want 0 0", busy_o, audio_sd_o);
                end
            end
            step();
        end
        checks++;
        if (bad_pwm != 0) begin errors++; $display("FAIL b2b_pwm got %0d bad cycles want 0", bad_pwm); end
        checks++;
        if (done_at.size() != 2) begin
            errors++; $display("FAIL b2b_done_count got %0d want 2", done_at.size());
        end else begin
            checks++;
            if (done_at[0] != 33 || done_at[1] - done_at[0] != 32) begin
                errors++; $display("FAIL b2b_done_spacing got %0d,%0d want 33,65", done_at[0], done_at[1]);
            end
        end
    endtask

    task automatic test_enable_drop();
        int bad = 0;
        data_i = 8'hC3; enable_i = 1'b1;
        step();
        for (int c = 1; c <= 32; c++) begin
            if (audio_pwm_o !== exp_bit(8'hC3, (c - 1) / 4) || audio_sd_o !== 1'b1 || done_o !== 1'b0) bad++;
            if (c == 10) enable_i = 1'b0;
            step();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL drop_bits got %0d bad cycles want 0", bad); end
        checks++;
        if ({done_o, audio_sd_o, audio_pwm_o, busy_o} !== 4'b1000) begin
            errors++; $display("FAIL drop_c33 got %b want 1000", {done_o, audio_sd_o, audio_pwm_o, busy_o});
        end
        step();
        checks++;
        if ({done_o, audio_sd_o, audio_pwm_o, busy_o} !== 4'b0000) begin
            errors++; $display("FAIL drop_c34 got %b want 0000", {done_o, audio_sd_o, audio_pwm_o, busy_o});
        end
    endtask

    task automatic test_reset_mid_word();
        data_i = 8'hFF; enable_i = 1'b1;
        step();
        for (int c = 1; c < 17; c++) step();
        reset_i = 1'b1;
        data_i = 8'h80;
        step();
        checks++;
        if ({done_o, audio_pwm_o, audio_sd_o, busy_o} !== 4'b0000) begin
            errors++; $display("FAIL midreset_outputs got %b want 0000", {done_o, audio_pwm_o, audio_sd_o, busy_o});
        end
        reset_i = 1'b0;
        step();
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (audio_pwm_o !== exp_bit(8'h80, (c - 1) / 4) || done_o !== 1'b0) begin
                errors++; $display("FAIL restart_c%0d got pwm %b done %b want %b 0", c, audio_pwm_o, done_o, exp_bit(8'h80, (c - 1) / 4));
            end
            step();
        end
        enable_i = 1'b0;
        for (int i = 0; i < 40 && busy_o; i++) step();
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL restart_drain got busy %b want 0", busy_o); end
    endtask

    initial begin
        reset_i = 1'b0; enable_i = 1'b0; data_i = 8'h00;
        test_reset();
        test_word(8'hA5);
        test_word(8'h01);
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
